// File: rtl/magic_buttons.sv
// magic_buttons: debounce Magic/Pause buttons, merge hotkeys, split short/long Magic presses
module magic_buttons #(
  parameter int CK35_PER_MS = 3500,
  parameter int DEBOUNCE_MS = 5,
  parameter int LONG_MS     = 2000
) (
  input  logic clk28,
  input  logic rst_n,
  input  logic ck35,
  input  logic n_int,
  input  logic n_int_next,
  input  logic magic_mode,
  input  logic btn_magic_n,
  input  logic btn_pause_n,
  input  logic kbd_magic,
  input  logic kbd_pause,
  output logic magic_button,
  output logic pause_button,
  output logic reboot_req
);
  localparam int PW = CK35_PER_MS > 1 ? $clog2(CK35_PER_MS) : 1;
  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;
  logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d, raw, deb_q, deb_d, hit, rise, fall;
  logic [1:0][DW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [10:0] hold_q, hold_d;
  state_t state_q, state_d;
  logic ms_tick, strobe, fsm_req, set_m, set_p, clr_m, clr_p;
  logic magic_req_q, magic_req_d, pause_req_q, pause_req_d;
  logic magic_vis_q, magic_vis_d, pause_vis_q, pause_vis_d;
  logic magic_button_q, magic_button_d, pause_button_q, pause_button_d, reboot_q, reboot_d;
  always_comb begin
    sync1_d = {btn_pause_n, btn_magic_n};
    sync2_d = sync1_q;
    raw = ~sync2_q;
    ms_tick = ck35 && pre_q == PW'(CK35_PER_MS - 1);
    pre_d = !ck35 ? pre_q : ms_tick ? '0 : pre_q + 1'b1;
    for (int i = 0; i < 2; i++) begin
      hit[i] = raw[i] != deb_q[i] && cnt_q[i] == DW'(DEBOUNCE_MS);
      cnt_d[i] = raw[i] == deb_q[i] || hit[i] ? '0 : cnt_q[i] + DW'(ms_tick);
    end
    deb_d = deb_q ^ hit;
    rise = hit & raw;
    fall = hit & ~raw;
  end
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    reboot_d = 1'b0;
    fsm_req = 1'b0;
    case (state_q)
      IDLE: if (rise[0]) begin
        hold_d = '0;
        state_d = HELD;
      end
      HELD: if (hold_q == 11'(LONG_MS)) begin
        reboot_d = 1'b1;
        state_d = LONG;
      end else if (fall[0]) begin
        fsm_req = 1'b1;
        state_d = IDLE;
      end else if (ms_tick) hold_d = hold_q + 11'd1;
      LONG: if (fall[0]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // a latch clears only at a strobe where its output is already visible, and a set wins
  always_comb begin
    strobe = n_int & ~n_int_next;
    set_m = fsm_req | kbd_magic;
    set_p = rise[1] | kbd_pause;
    clr_m = strobe & magic_vis_q & ~set_m;
    clr_p = strobe & pause_vis_q & ~set_p;
    magic_req_d = set_m | (magic_req_q & ~clr_m);
    pause_req_d = set_p | (pause_req_q & ~clr_p);
    magic_vis_d = magic_req_q & ~clr_m;
    pause_vis_d = pause_req_q & ~clr_p;
    magic_button_d = magic_mode ? deb_q[0] : magic_vis_d;
    pause_button_d = pause_vis_d | deb_q[1];
  end
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      deb_q <= '0;
      cnt_q <= '0;
      pre_q <= '0;
      hold_q <= '0;
      state_q <= IDLE;
      magic_req_q <= 1'b0;
      pause_req_q <= 1'b0;
      magic_vis_q <= 1'b0;
      pause_vis_q <= 1'b0;
      magic_button_q <= 1'b0;
      pause_button_q <= 1'b0;
      reboot_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
      pre_q <= pre_d;
      hold_q <= hold_d;
      state_q <= state_d;
      magic_req_q <= magic_req_d;
      pause_req_q <= pause_req_d;
      magic_vis_q <= magic_vis_d;
      pause_vis_q <= pause_vis_d;
      magic_button_q <= magic_button_d;
      pause_button_q <= pause_button_d;
      reboot_q <= reboot_d;
    end
  end
  assign magic_button = magic_button_q;
  assign pause_button = pause_button_q;
  assign reboot_req = reboot_q;
endmodule

// File: tb/tb_magic_buttons.sv
// tb_magic_buttons: directed checks of magic_buttons with 1 ms = 16 clk28 cycles
module tb_magic_buttons;
  logic clk28 = 1'b0, rst_n = 1'b0, ck35 = 1'b0, n_int = 1'b1, n_int_next = 1'b1, magic_mode = 1'b0;
  logic btn_magic_n = 1'b1, btn_pause_n = 1'b1, kbd_magic = 1'b0, kbd_pause = 1'b0;
  logic magic_button, pause_button, reboot_req;
  int checks = 0, errors = 0, reboots = 0;
  magic_buttons #(.CK35_PER_MS(2), .DEBOUNCE_MS(3), .LONG_MS(12)) dut (
    .clk28(clk28), .rst_n(rst_n), .ck35(ck35), .n_int(n_int), .n_int_next(n_int_next),
    .magic_mode(magic_mode), .btn_magic_n(btn_magic_n), .btn_pause_n(btn_pause_n),
    .kbd_magic(kbd_magic), .kbd_pause(kbd_pause), .magic_button(magic_button),
    .pause_button(pause_button), .reboot_req(reboot_req)
  );
  always #5 clk28 = ~clk28;
  initial begin : ck_gen
    int n;
    n = 0;
    forever begin
      @(negedge clk28);
      ck35 = n == 7;
      n = n == 7 ? 0 : n + 1;
    end
  end
  always @(posedge clk28) if (reboot_req) reboots <= reboots + 1;
  task automatic cyc(input int n);
    repeat (n) @(negedge clk28);
  endtask
  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic strobe();
    n_int_next = 1'b0;
    @(negedge clk28);
    n_int_next = 1'b1;
  endtask
  initial begin
    cyc(3);
    chk("rst_magic", magic_button, 1'b0);
    chk("rst_pause", pause_button, 1'b0);
    chk("rst_reboot", reboot_req, 1'b0);
    rst_n = 1'b1;
    cyc(5);
    // hotkey, then a strobe before the output is visible must not clear it
    kbd_magic = 1'b1;
    cyc(1);
    kbd_magic = 1'b0;
    chk("kbd_lat1", magic_button, 1'b0);
    strobe();
    chk("kbd_lat2_early_strobe", magic_button, 1'b1);
    cyc(3);
    chk("kbd_hold", magic_button, 1'b1);
    strobe();
    chk("kbd_clear", magic_button, 1'b0);
    cyc(2);
    chk("kbd_stay_clear", magic_button, 1'b0);
    // hotkey in the same cycle as a strobe
    kbd_magic = 1'b1;
    n_int_next = 1'b0;
    cyc(1);
    kbd_magic = 1'b0;
    n_int_next = 1'b1;
    chk("coll_lat1", magic_button, 1'b0);
    cyc(1);
    chk("coll_lat2", magic_button, 1'b1);
    cyc(4);
    chk("coll_hold", magic_button, 1'b1);
    kbd_magic = 1'b1;
    strobe();
    kbd_magic = 1'b0;
    chk("set_wins", magic_button, 1'b1);
    cyc(2);
    chk("set_wins_hold", magic_button, 1'b1);
    strobe();
    chk("coll_clear", magic_button, 1'b0);
    kbd_pause = 1'b1;
    cyc(1);
    kbd_pause = 1'b0;
    cyc(1);
    chk("kbd_pause", pause_button, 1'b1);
    strobe();
    chk("kbd_pause_clear", pause_button, 1'b0);
    // short Magic press
    btn_magic_n = 1'b0;
    cyc(128);
    chk("short_held", magic_button, 1'b0);
    btn_magic_n = 1'b1;
    cyc(30);
    chk("short_early", magic_button, 1'b0);
    cyc(30);
    chk("short_req", magic_button, 1'b1);
    chki("short_no_reboot", reboots, 0);
    strobe();
    chk("short_clear", magic_button, 1'b0);
    // long Magic press
    btn_magic_n = 1'b0;
    cyc(200);
    chki("long_before", reboots, 0);
    cyc(60);
    chki("long_reboot", reboots, 1);
    chk("long_no_req", magic_button, 1'b0);
    cyc(60);
    btn_magic_n = 1'b1;
    cyc(80);
    chki("long_once", reboots, 1);
    chk("long_release", magic_button, 1'b0);
    strobe();
    chk("long_after_strobe", magic_button, 1'b0);
    // pause bounce, 1 ms per level
    for (int i = 0; i < 20; i++) begin
      btn_pause_n = ~btn_pause_n;
      cyc(16);
      chk("bounce", pause_button, 1'b0);
    end
    cyc(80);
    chk("bounce_settled", pause_button, 1'b0);
    // pause press: level while held, request held after release
    btn_pause_n = 1'b0;
    cyc(30);
    chk("pause_early", pause_button, 1'b0);
    cyc(30);
    chk("pause_level", pause_button, 1'b1);
    btn_pause_n = 1'b1;
    cyc(80);
    chk("pause_req_held", pause_button, 1'b1);
    strobe();
    chk("pause_clear", pause_button, 1'b0);
    // magic mode passthrough
    magic_mode = 1'b1;
    btn_magic_n = 1'b0;
    cyc(60);
    chk("mode_level", magic_button, 1'b1);
    cyc(68);
    chk("mode_level_held", magic_button, 1'b1);
    btn_magic_n = 1'b1;
    cyc(30);
    chk("mode_release_early", magic_button, 1'b1);
    cyc(30);
    chk("mode_release", magic_button, 1'b0);
    magic_mode = 1'b0;
    cyc(2);
    chk("mode_req_latched", magic_button, 1'b1);
    strobe();
    chk("mode_req_clear", magic_button, 1'b0);
    // reset in the middle of a press
    kbd_pause = 1'b1;
    cyc(1);
    kbd_pause = 1'b0;
    cyc(1);
    chk("pre_rst_pause", pause_button, 1'b1);
    magic_mode = 1'b1;
    btn_magic_n = 1'b0;
    cyc(70);
    chk("pre_rst_magic", magic_button, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_magic", magic_button, 1'b0);
    chk("midrst_pause", pause_button, 1'b0);
    chk("midrst_reboot", reboot_req, 1'b0);
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    chk("postrst_early", magic_button, 1'b0);
    cyc(40);
    chk("postrst_press", magic_button, 1'b1);
    btn_magic_n = 1'b1;
    magic_mode = 1'b0;
    cyc(25);
    chk("postrst_no_req", magic_button, 1'b0);
    cyc(35);
    chk("postrst_req", magic_button, 1'b1);
    strobe();
    chk("postrst_clear", magic_button, 1'b0);
    chki("final_reboots", reboots, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
